// File: rtl/bsg_strobe_token_bucket.sv
// Token-bucket rate limiter between a valid/ready producer and consumer.
// Each strobe_i pulse grants one token. Every accepted payload spends one token
// and passes through a one-entry output register.
// The optional macro BSG_TOKEN_BUCKET_BURST_EN sets the bucket depth:
//   - defined: the bucket holds up to bucket_max_p tokens.
//   - undefined: the bucket holds one token (strict rate).
module bsg_strobe_token_bucket #(
    parameter int unsigned width_p      = 8,
    parameter int unsigned bucket_max_p = 15
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   strobe_i,
    input  logic                                   v_i,
    input  logic [width_p-1:0]                     data_i,
    output logic                                   ready_o,
    output logic                                   v_o,
    output logic [width_p-1:0]                     data_o,
    input  logic                                   ready_i,
    output logic [$clog2(bucket_max_p+1)-1:0]      tokens_o,
    output logic                                   drop_o
);

    localparam int unsigned TokW = $clog2(bucket_max_p + 1);
`ifdef BSG_TOKEN_BUCKET_BURST_EN
    localparam int unsigned CapInt = bucket_max_p;
`else
    localparam int unsigned CapInt = 1;
`endif
    localparam logic [TokW-1:0] CapTok = TokW'(CapInt);

    logic [TokW-1:0]    tokens_q, tokens_d;
    logic               v_q, v_d;
    logic [width_p-1:0] data_q, data_d;
    logic               drop_q, drop_d;
    logic               accept;

    // Handshake: a token must be available and the output slot must be free or draining.
    always_comb begin
        ready_o = (tokens_q != '0) & (~v_q | ready_i);
        accept  = v_i & ready_o;
    end

    // Token count. A strobe in the same cycle as an accept cancels it out.
    // A strobe that arrives when the bucket is full is discarded and reported on drop_o.
    always_comb begin
        tokens_d = tokens_q;
        drop_d   = 1'b0;
        if (strobe_i && !accept) begin
            if (tokens_q != CapTok) begin
                tokens_d = tokens_q + TokW'(1);
            end else begin
                drop_d = 1'b1;
            end
        end else if (accept && !strobe_i) begin
            tokens_d = tokens_q - TokW'(1);
        end
    end

    // Output slot: fill on accept, empty on drain, otherwise hold.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (accept) begin
            v_d    = 1'b1;
            data_d = data_i;
        end else if (ready_i) begin
            v_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously so a held payload is discarded at once.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tokens_q <= '0;
            v_q      <= 1'b0;
            data_q   <= '0;
            drop_q   <= 1'b0;
        end else begin
            tokens_q <= tokens_d;
            v_q      <= v_d;
            data_q   <= data_d;
            drop_q   <= drop_d;
        end
    end

    // Drive the outputs straight from the registers.
    always_comb begin
        v_o      = v_q;
        data_o   = data_q;
        tokens_o = tokens_q;
        drop_o   = drop_q;
    end

endmodule

// File: tb/tb_bsg_strobe_token_bucket.sv
// Directed bench for bsg_strobe_token_bucket with width_p=8 and bucket_max_p=4.
// Expectations follow the build: the bucket depth is 4 with BSG_TOKEN_BUCKET_BURST_EN, else 1.
module tb_bsg_strobe_token_bucket;

`ifdef BSG_TOKEN_BUCKET_BURST_EN
    localparam int Cap = 4;
`else
    localparam int Cap = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       strobe;
    logic       v_in;
    logic [7:0] data_in;
    logic       ready_out;
    logic       v_out;
    logic [7:0] data_out;
    logic       ready_in;
    logic [2:0] tokens;
    logic       drop;

    int total = 0;
    int passed = 0;
    int fails = 0;

    bsg_strobe_token_bucket #(
        .width_p     (8),
        .bucket_max_p(4)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .strobe_i (strobe),
        .v_i      (v_in),
        .data_i   (data_in),
        .ready_o  (ready_out),
        .v_o      (v_out),
        .data_o   (data_out),
        .ready_i  (ready_in),
        .tokens_o (tokens),
        .drop_o   (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int drops;
        int xfers;
        int min_k;

        reset_n  = 1'b0;
        strobe   = 1'b1;
        v_in     = 1'b1;
        data_in  = 8'hFF;
        ready_in = 1'b1;

        // Inputs asserted during reset are ignored.
        step();
        chk("rst_tokens", 32'(tokens), 0);
        chk("rst_v_o", 32'(v_out), 0);
        chk("rst_data_o", 32'(data_out), 0);
        chk("rst_drop", 32'(drop), 0);
        chk("rst_ready", 32'(ready_out), 0);

        strobe  = 1'b0;
        reset_n = 1'b1;

        // With no strobes, no tokens arrive and nothing can be accepted.
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("nostrobe_ready", 32'(ready_out), 0);
            step();
            chk("nostrobe_v_o", 32'(v_out), 0);
            chk("nostrobe_tokens", 32'(tokens), 0);
        end

        // Cap+2 strobes with v_i low: the count saturates and two grants are dropped.
        v_in  = 1'b0;
        drops = 0;
        for (int k = 1; k <= Cap + 2; k++) begin
            strobe = 1'b1;
            step();
            min_k = (k < Cap) ? k : Cap;
            chk("fill_tokens", 32'(tokens), 32'(min_k));
            chk("fill_drop", 32'(drop), ((k - 1) >= Cap) ? 1 : 0);
            if (drop) drops++;
        end
        strobe = 1'b0;
        step();
        chk("fill_drop_after", 32'(drop), 0);
        chk("fill_drop_count", 32'(drops), 2);

        // Burst drain: one transfer per cycle while tokens last, with 1-cycle latency.
        v_in     = 1'b1;
        ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = 8'hA0 + 8'(i);
            #1;
            chk("burst_ready", 32'(ready_out), (i < Cap) ? 1 : 0);
            step();
            chk("burst_v_o", 32'(v_out), (i < Cap) ? 1 : 0);
            if (i < Cap) chk("burst_data", 32'(data_out), 32'(8'hA0 + 8'(i)));
            chk("burst_tokens", 32'(tokens), (Cap - 1 - i > 0) ? 32'(Cap - 1 - i) : 0);
        end
        v_in = 1'b0;
        step();

        // A strobe and an accept in the same cycle leave the count at 1.
        strobe = 1'b1;
        step();
        chk("one_tokens", 32'(tokens), 1);
        v_in    = 1'b1;
        data_in = 8'h77;
        #1;
        chk("same_ready", 32'(ready_out), 1);
        step();
        chk("same_tokens", 32'(tokens), 1);
        chk("same_drop", 32'(drop), 0);
        chk("same_v_o", 32'(v_out), 1);
        chk("same_data", 32'(data_out), 32'h77);
        strobe = 1'b0;
        v_in   = 1'b0;
        step();
        chk("same_drain_v_o", 32'(v_out), 0);
        chk("same_drain_tokens", 32'(tokens), 1);

        // Stall: the payload is held while ready_i is low, and then reset drops it.
        strobe   = 1'b1;
        v_in     = 1'b1;
        data_in  = 8'h5C;
        ready_in = 1'b0;
        step();
        chk("stall_load_v_o", 32'(v_out), 1);
        chk("stall_load_data", 32'(data_out), 32'h5C);
        strobe  = 1'b0;
        data_in = 8'h33;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_ready", 32'(ready_out), 0);
            step();
            chk("stall_v_o", 32'(v_out), 1);
            chk("stall_data", 32'(data_out), 32'h5C);
            chk("stall_tokens", 32'(tokens), 1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_v_o", 32'(v_out), 0);
        chk("async_rst_data", 32'(data_out), 0);
        chk("async_rst_tokens", 32'(tokens), 0);
        step();
        reset_n = 1'b1;

        // Rate limit: with sustained demand there is one transfer per strobe.
        v_in     = 1'b1;
        ready_in = 1'b1;
        xfers    = 0;
        for (int c = 0; c < 11; c++) begin
            strobe  = (c % 3 == 0);
            data_in = 8'h10 + 8'(c);
            step();
            if (v_out) xfers++;
            chk("rate_drop", 32'(drop), 0);
        end
        strobe = 1'b0;
        v_in   = 1'b0;
        step();
        chk("rate_xfers", 32'(xfers), 4);
        chk("rate_tokens_end", 32'(tokens), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Bound the run so that a stuck simulation still terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
